unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port memory between the core's instruction-fetch port and its load/store data port.
- The pipelined core stalls on each port until this block returns a one-cycle completion pulse.
- Sits between the core and the memory subsystem.
- Sequences the memory req/ack handshake and grants data accesses priority, with a starvation guard for fetch.

Parameters:
DATA_WIDTH, 32, width of instruction, read and write data
ADDR_WIDTH, 32, width of all addresses
MAX_DATA_BURST, 4, consecutive data grants allowed while a fetch is pending before fetch is forced (range 1..15)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
if_req  input  1  fetch request, held until if_valid
if_addr  input  ADDR_WIDTH  fetch address (PC)
if_rdata  output  DATA_WIDTH  fetched instruction, registered
if_valid  output  1  one-cycle pulse: fetch complete, if_rdata valid
d_read  input  1  load request, held until d_done
d_write  input  1  store request, held until d_done
d_addr  input  ADDR_WIDTH  load/store address
d_wdata  input  DATA_WIDTH  store data
d_rdata  output  DATA_WIDTH  load data, registered
d_done  output  1  one-cycle pulse: data access complete
mem_req  output  1  memory request, registered
mem_we  output  1  1 = write
mem_addr  output  ADDR_WIDTH  memory address, registered
mem_wdata  output  DATA_WIDTH  memory write data, registered
mem_rdata  input  DATA_WIDTH  memory read data, valid when mem_ack=1
mem_ack  input  1  memory completes the current request this cycle
busy  output  1  state != IDLE

Behaviour:
- Reset: on a rising edge with rst=0, the following take their reset values at that edge, regardless of any in-flight transaction:
  - state = IDLE, burst count = 0.
  - All outputs 0, including if_rdata, d_rdata, mem_addr and mem_wdata.
  - An abandoned memory request is dropped; the memory must tolerate this.
- FSM states are IDLE, FETCH, DATA and RESP.
- IDLE arbitration, evaluated every cycle in IDLE:
  - Data pending (d_read|d_write) and burst count < MAX_DATA_BURST → DATA.
  - Else if_req → FETCH.
  - Else data pending (count saturated, no fetch pending) → DATA.
  - Else stay in IDLE.
- On the grant edge:
  - mem_req <= 1.
  - mem_addr/mem_we/mem_wdata latch from the granted port.
  - d_write=1 → mem_we=1, including when d_read=1 too (the illegal both-high case resolves as a store).
  - Fetch grant → mem_we=0.
- FETCH/DATA:
  - mem_req and the mem_* lines stay stable until a cycle with mem_ack=1.
  - On that edge: mem_req <= 0, go to RESP, and mem_rdata is captured into if_rdata (fetch) or d_rdata (load).
  - A store leaves d_rdata unchanged.
- RESP:
  - Exactly one cycle, with if_valid or d_done = 1 for the completed port.
  - Requests are ignored in this cycle, which prevents a duplicate issue on stale held requests.
  - Next state is always IDLE.
- Requester rule: drop or change the request on the edge ending the pulse cycle.
- A request deasserted mid-transaction does not abort it; the transaction completes and the pulse is still issued.
- Minimum latency:
  - Request visible at edge N → mem_req high in cycle N+1.
  - mem_ack in cycle N+1 → pulse in cycle N+2.
  - Next grant no earlier than edge N+3.
- Throughput: at most one transaction per 3 cycles.
- Burst counter, updated on the grant edge:
  - Data grant while if_req=1 → count+1, saturating at MAX_DATA_BURST.
  - Fetch grant, or data grant with if_req=0 → count = 0.
- mem_ack outside FETCH/DATA is ignored.
- if_rdata and d_rdata hold their last value until their next completed read.

Decomposition:
- Package Mem_Arbiter_enum holds:
  - the state typedef (IDLE, FETCH, DATA, RESP; 2-bit encoding);
  - the grant-source typedef (GNT_FETCH, GNT_DATA).
- One sub-module, burst_counter: a saturating counter with clear, increment and a saturated flag, parameterised by MAX_DATA_BURST.

Test Plan:
- Reset mid-transaction:
  - Stimulus: if_req=1, if_addr=0x100; hold rst=0 for 1 edge while mem_req=1.
  - Response: mem_req=0, busy=0 and all outputs 0 next cycle; no if_valid; with rst=1 and if_req still 1, reissue at 0x100.
- Single fetch:
  - Stimulus: if_addr=0x0000_0040, memory acks 2 cycles after mem_req, mem_rdata=0x0050_0093.
  - Response: mem_we=0, mem_addr=0x40; if_valid pulses one cycle later with if_rdata=0x0050_0093; busy falls the cycle after.
- Simultaneous requests:
  - Stimulus: if_req=1 (0x44) and d_read=1 (0x2000) in the same cycle.
  - Response: data is granted first (mem_addr=0x2000); d_done pulses; then fetch at 0x44 is granted; if_valid pulses.
- Store with both flags:
  - Stimulus: d_write=1, d_read=1, d_addr=0x3000, d_wdata=0xDEADBEEF.
  - Response: mem_we=1, mem_wdata=0xDEADBEEF; d_done pulses; d_rdata is unchanged.
- Starvation guard:
  - Stimulus: MAX_DATA_BURST=4; if_req held; d_read held continuously, never dropping.
  - Response: exactly 4 data grants, then 1 fetch grant, then data again; the counter resets after the fetch.
- Zero-wait memory:
  - Stimulus: mem_ack tied 1; alternating fetch and load requests.
  - Response: 3-cycle spacing between grants; no duplicate transaction during RESP; mem_ack in IDLE is ignored.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified fetch/data memory arbiter.
// State encoding, grant source and burst counter width.
package Mem_Arbiter_enum;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_t;

    // Wide enough for the largest allowed MAX_DATA_BURST (15).
    localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/unified_mem_arbiter_burst_counter.sv
// Saturating count of back-to-back data grants taken while a fetch waits.
// Updates one cycle after clr/inc; sat is combinational from the count.
module burst_counter
    import Mem_Arbiter_enum::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic sat
);

    logic [BURST_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count >= BURST_CNT_W'(MAX_DATA_BURST));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, data first with a fetch starvation guard.
// Grant edge -> mem_req next cycle; ack -> completion pulse next cycle; requesters hold their request until the pulse.
module unified_mem_arbiter
    import Mem_Arbiter_enum::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy
);

    state_t state;
    state_t state_next;
    gnt_t   gnt_src;
    logic   grant_fetch;
    logic   grant_data;
    logic   data_pend;
    logic   burst_sat;
    logic   burst_clr;
    logic   burst_inc;

    assign data_pend = d_read | d_write;

    always_comb begin
        state_next  = state;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        case (state)
            IDLE: begin
                if (data_pend && !burst_sat) begin
                    grant_data = 1'b1;
                end else if (if_req) begin
                    grant_fetch = 1'b1;
                end else if (data_pend) begin
                    grant_data = 1'b1;
                end
                if (grant_data) begin
                    state_next = DATA;
                end else if (grant_fetch) begin
                    state_next = FETCH;
                end
            end
            FETCH, DATA: begin
                if (mem_ack) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Data grants only count against fetch while a fetch is actually waiting.
    assign burst_inc = grant_data & if_req;
    assign burst_clr = grant_fetch | (grant_data & ~if_req);

    burst_counter #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_burst_counter (
        .clk (clk),
        .rst (rst),
        .clr (burst_clr),
        .inc (burst_inc),
        .sat (burst_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            gnt_src   <= GNT_FETCH;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_next;
            if (grant_data) begin
                gnt_src   <= GNT_DATA;
                mem_req   <= 1'b1;
                mem_we    <= d_write;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_fetch) begin
                gnt_src   <= GNT_FETCH;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
            if ((state == FETCH || state == DATA) && mem_ack) begin
                mem_req <= 1'b0;
                if (state == FETCH) begin
                    if_rdata <= mem_rdata;
                end else if (!mem_we) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

    assign if_valid = (state == RESP) && (gnt_src == GNT_FETCH);
    assign d_done   = (state == RESP) && (gnt_src == GNT_DATA);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboarded directed bench for unified_mem_arbiter: grants and completions are checked by monitors against queued expectations.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } gnt_exp_t;

    gnt_exp_t    exp_gnt[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];

    int n_tests      = 0;
    int n_fail       = 0;
    int ack_delay    = 1;
    bit ack_tie      = 0;
    int wcnt         = 0;
    int cyc          = 0;
    bit spacing_en   = 0;
    int last_gnt_cyc = -1;
    bit prev_req     = 0;

    unified_mem_arbiter #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .MAX_DATA_BURST(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0050_0093;
        return {16'hA5A5, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory responder: ack after ack_delay cycles of mem_req, or every cycle when tied.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (ack_tie) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_model(mem_addr);
            end else if (mem_req && wcnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_model(mem_addr);
                wcnt      = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt    = mem_req ? wcnt + 1 : 0;
            end
        end
    end

    // Grant monitor
    initial begin
        gnt_exp_t g;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                if (exp_gnt.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant: addr %h we %b, no grant expected", mem_addr, mem_we);
                end else begin
                    g = exp_gnt.pop_front();
                    chk("grant_addr", mem_addr, g.addr);
                    chk("grant_we", 32'(mem_we), 32'(g.we));
                    if (g.we) chk("grant_wdata", mem_wdata, g.wdata);
                    if (spacing_en) begin
                        if (last_gnt_cyc >= 0) chk("grant_spacing", 32'(cyc - last_gnt_cyc), 32'd3);
                        last_gnt_cyc = cyc;
                    end
                end
            end
            prev_req = mem_req;
        end
    end

    // Completion monitor
    initial begin
        forever begin
            @(negedge clk);
            if (if_valid) begin
                if (exp_if.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_if_valid: if_rdata %h, no fetch outstanding", if_rdata);
                end else begin
                    chk("if_rdata", if_rdata, exp_if.pop_front());
                end
            end
            if (d_done) begin
                if (exp_d.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_d_done: d_rdata %h, no data access outstanding", d_rdata);
                end else begin
                    chk("d_rdata", d_rdata, exp_d.pop_front());
                end
            end
        end
    end

    task automatic wait_pulse(input bit data_port, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (data_port ? d_done : if_valid) begin
                hit = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: got no pulse, expected one within 300 cycles", nm);
        end
    endtask

    task automatic fetch_txn(input logic [31:0] a);
        if_addr = a;
        if_req  = 1'b1;
        wait_pulse(1'b0, "fetch_timeout");
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic data_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        d_addr  = a;
        d_wdata = wd;
        d_read  = rd;
        d_write = wr;
        wait_pulse(1'b1, "data_timeout");
        @(posedge clk);
        #1;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic push_gnt(input logic [31:0] a, input logic we, input logic [31:0] wd);
        gnt_exp_t g;
        g.addr  = a;
        g.we    = we;
        g.wdata = wd;
        exp_gnt.push_back(g);
    endtask

    initial begin
        bit seen;
        rst     = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_read  = 1'b0;
        d_write = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_if_rdata", if_rdata, 32'd0);
        chk("reset_d_rdata", d_rdata, 32'd0);
        chk("reset_pulses", 32'({if_valid, d_done}), 32'd0);
        rst = 1'b1;

        // Reset while a fetch is outstanding, then the held request reissues.
        ack_delay = 5;
        push_gnt(32'h100, 1'b0, 32'h0);
        if_addr = 32'h100;
        if_req  = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rstmid_grant: got no mem_req, expected one within 20 cycles");
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_req", 32'(mem_req), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_mem_addr", mem_addr, 32'd0);
        chk("rstmid_mem_we", 32'(mem_we), 32'd0);
        chk("rstmid_if_rdata", if_rdata, 32'd0);
        rst       = 1'b1;
        ack_delay = 1;
        push_gnt(32'h100, 1'b0, 32'h0);
        exp_if.push_back(32'hA5A5_0100);
        wait_pulse(1'b0, "rstmid_reissue_timeout");
        @(posedge clk);
        #1;
        if_req = 1'b0;

        // Single fetch, memory acks two cycles after mem_req.
        ack_delay = 2;
        push_gnt(32'h40, 1'b0, 32'h0);
        exp_if.push_back(32'h0050_0093);
        if_addr = 32'h40;
        if_req  = 1'b1;
        wait_pulse(1'b0, "single_fetch_timeout");
        chk("single_busy_in_pulse", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("single_busy_after", 32'(busy), 32'd0);
        chk("single_if_rdata_hold", if_rdata, 32'h0050_0093);

        // Simultaneous fetch and load: data wins, then fetch.
        ack_delay = 1;
        push_gnt(32'h2000, 1'b0, 32'h0);
        push_gnt(32'h44, 1'b0, 32'h0);
        exp_d.push_back(32'hA5A5_2000);
        exp_if.push_back(32'hA5A5_0044);
        fork
            fetch_txn(32'h44);
            data_txn(1'b1, 1'b0, 32'h2000, 32'h0);
        join

        // Read and write both high resolves as a store; d_rdata keeps the last load.
        push_gnt(32'h3000, 1'b1, 32'hDEAD_BEEF);
        exp_d.push_back(32'hA5A5_2000);
        data_txn(1'b1, 1'b1, 32'h3000, 32'hDEAD_BEEF);

        // Starvation guard: four data grants, forced fetch, then data again.
        for (int i = 0; i < 4; i++) push_gnt(32'h5000, 1'b0, 32'h0);
        push_gnt(32'h80, 1'b0, 32'h0);
        push_gnt(32'h5000, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) exp_d.push_back(32'hA5A5_5000);
        exp_if.push_back(32'hA5A5_0080);
        fork
            fetch_txn(32'h80);
            begin
                d_addr = 32'h5000;
                d_read = 1'b1;
                for (int i = 0; i < 5; i++) wait_pulse(1'b1, "starve_data_timeout");
                @(posedge clk);
                #1;
                d_read = 1'b0;
            end
        join

        // Zero-wait memory, alternating fetch and load.
        repeat (2) @(negedge clk);
        ack_tie      = 1'b1;
        last_gnt_cyc = -1;
        spacing_en   = 1'b1;
        push_gnt(32'h60, 1'b0, 32'h0);
        push_gnt(32'h6000, 1'b0, 32'h0);
        push_gnt(32'h64, 1'b0, 32'h0);
        push_gnt(32'h6004, 1'b0, 32'h0);
        exp_if.push_back(32'hA5A5_0060);
        exp_d.push_back(32'hA5A5_6000);
        exp_if.push_back(32'hA5A5_0064);
        exp_d.push_back(32'hA5A5_6004);
        fetch_txn(32'h60);
        data_txn(1'b1, 1'b0, 32'h6000, 32'h0);
        fetch_txn(32'h64);
        data_txn(1'b1, 1'b0, 32'h6004, 32'h0);
        spacing_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ack_busy", 32'(busy), 32'd0);
        chk("idle_ack_mem_req", 32'(mem_req), 32'd0);
        ack_tie = 1'b0;

        repeat (5) @(negedge clk);
        chk("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);
        chk("if_queue_drained", 32'(exp_if.size()), 32'd0);
        chk("d_queue_drained", 32'(exp_d.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
